mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single unified memory bus between the fetch stage (instruction port) and the memory stage (data port). It sits between those two stages and the external memory/MMIO interconnect. A registered four-state FSM issues one transaction at a time, with data-over-fetch priority and a bounded fetch-starvation counter. It also provides fetch-abort handling for redirects and a response timeout that reports access faults to the requesters.

## Interface
Parameters:
- D_BURST_MAX, 4: max consecutive data grants while I_REQ is pending; then fetch is forced.
- TIMEOUT_CYCLES, 255: cycles in ISSUE+WAIT before a fault is returned (≥2).

Ports (name, direction, width, meaning):
- Clocking and reset
  - CLK, in, 1: single clock; all state on rising edge.
  - RESET, in, 1: asynchronous, active-low reset.
- Instruction port
  - I_REQ, in, 1: fetch request; held until I_DONE or abort.
  - I_ADDR, in, 64: fetch address.
  - I_ABORT, in, 1: discard the in-flight or pending fetch (branch/trap redirect).
  - I_DONE, out, 1: one-cycle completion pulse.
  - I_RDATA, out, 32: instruction word, selected by ADDR[2] of the latched address.
  - I_ERR, out, 1: fault, valid with I_DONE (feeds FE_IAF).
- Data port
  - D_REQ, in, 1: data request; held until D_DONE.
  - D_WE, in, 1: 1 = store.
  - D_ADDR, in, 64: data address.
  - D_WDATA, in, 64: store data.
  - D_WSTRB, in, 8: byte enables.
  - D_DONE, out, 1: one-cycle completion pulse.
  - D_RDATA, out, 64: load data.
  - D_ERR, out, 1: fault, valid with D_DONE (feeds MEM_LAF/MEM_SAF).
- Bus port
  - BUS_REQ, out, 1: request valid.
  - BUS_WE, out, 1: write.
  - BUS_ADDR, out, 64: aligned 8-byte address (low 3 bits zero).
  - BUS_WDATA, out, 64: write data.
  - BUS_WSTRB, out, 8: byte enables; 0xFF for fetch.
  - BUS_READY, in, 1: request accepted this cycle.
  - BUS_RVALID, in, 1: response valid.
  - BUS_RDATA, in, 64: response data.
  - BUS_ERR, in, 1: error, valid with BUS_RVALID.

## Operation
- States:
  - IDLE: samples requests.
  - ISSUE: BUS_REQ high with registered address/data/strobe/WE.
  - WAIT: awaiting BUS_RVALID.
  - RESP: the DONE pulse cycle.
- IDLE grant rules:
  - D_REQ && !(I_REQ && burst_cnt==D_BURST_MAX) → grant D.
  - Else I_REQ && !I_ABORT → grant I.
  - The grant latches owner, address (low 3 bits cleared), WE (fetch forces 0), WDATA, WSTRB into registers; next state ISSUE.
- burst_cnt (width clog2(D_BURST_MAX+1)):
  - +1 on each D grant while I_REQ is high.
  - Cleared on an I grant, or in any IDLE cycle with I_REQ low.
  - Saturates at D_BURST_MAX.
- Transitions:
  - ISSUE → WAIT on BUS_READY.
  - WAIT → RESP on BUS_RVALID.
  - RESP → IDLE unconditionally. Requests are not sampled in RESP, so a back-to-back requester sees a one-cycle IDLE gap.
- RESP outputs:
  - The owner's DONE = 1 and ERR = BUS_ERR (registered).
  - I_RDATA = ADDR[2] ? RDATA[63:32] : RDATA[31:0]; D_RDATA = BUS_RDATA (registered).
  - Non-owner DONE = 0.
- Abort:
  - I_ABORT in ISSUE/WAIT with owner I sets an abort flag. The transaction still completes on the bus, but RESP suppresses I_DONE.
  - I_ABORT in IDLE blocks an I grant that cycle.
  - I_ABORT never affects a data transaction.
- Timeout:
  - timeout_cnt clears on grant and increments each ISSUE/WAIT cycle.
  - On reaching TIMEOUT_CYCLES: go to RESP with owner DONE=1, ERR=1, RDATA=0, and drop BUS_REQ.
  - A BUS_RVALID arriving in IDLE or RESP, or any RVALID not preceded by READY, is ignored.
- Reset:
  - All outputs 0; state IDLE; counters 0; abort flag 0.
  - Reset mid-transaction drops BUS_REQ immediately (async) and produces no DONE.

## Timing
- BUS_REQ is asserted the cycle after the grant and is held with stable ADDR/WE/WDATA/WSTRB until BUS_READY.
- Minimum latency, with BUS_READY in the ISSUE cycle and RVALID in the first WAIT cycle:
  - REQ sampled in cycle 0, BUS_REQ in cycle 1, RVALID in cycle 2, DONE in cycle 3.
- DONE is exactly one cycle; the requester may change ADDR in the cycle after DONE.
- RDATA/ERR are valid only in the DONE cycle.
- Simultaneous I_REQ and D_REQ in IDLE: D wins unless burst_cnt==D_BURST_MAX.

## Structure
- Shared package:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP).
  - Owner encoding (OWN_I, OWN_D).
  - Constants XLEN=64, ILEN=32, STRB_W=8.
- Sub-module mem_arb_timeout: counter plus expiry flag, with clear/enable inputs.
- FSM, grant logic and response registers live in the top module.

## Test plan
- Single fetch, I_ADDR=0x1004, READY immediate, RVALID one cycle later with RDATA=0xAAAA_BBBB_1111_2222:
  - BUS_ADDR=0x1000, WSTRB=0xFF.
  - I_DONE in cycle 3 with I_RDATA=0xAAAA_BBBB.
- Store D_ADDR=0x2000, D_WSTRB=0x0F, D_WDATA=0x55:
  - BUS_WE=1 and BUS_WSTRB=0x0F held through 3 stall cycles of BUS_READY=0.
  - D_DONE once, D_ERR=0.
- I_REQ and D_REQ held continuously, D_BURST_MAX=4:
  - Grant order D,D,D,D,I,D…
  - burst_cnt clears after the I grant.
- I_ABORT in WAIT of a fetch, then a new I_REQ:
  - Old response produces no I_DONE.
  - Next fetch issues after RESP→IDLE.
- BUS_RVALID never returns, TIMEOUT_CYCLES=8:
  - D_DONE with D_ERR=1 eight cycles after grant.
  - A late RVALID in IDLE is ignored.
- RESET low during WAIT:
  - BUS_REQ/DONE outputs 0 at once.
  - After release, a pending D_REQ is regranted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ==========================================================================
// mem_arbiter_pkg : shared types and constants for the unified-bus arbiter
// Rev 1.0
// ==========================================================================
package mem_arbiter_pkg;

    localparam int XLEN   = 64;
    localparam int ILEN   = 32;
    localparam int STRB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic logic [XLEN-1:0] align8(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timeout.sv
`default_nettype none
// ==========================================================================
// mem_arb_timeout : response-timeout counter with single-cycle expiry flag
// Rev 1.0
// ==========================================================================
module mem_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_expire_at = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    // The grant cycle counts toward the budget, so the fault response lands
    // exactly TIMEOUT_CYCLES cycles after the grant.
    assign w_expired = i_enable && (r_cnt == c_expire_at);
    assign o_expired = w_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_arbiter : fetch/data arbiter for the unified memory bus
// Rev 1.0
// ==========================================================================
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int D_BURST_MAX    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_REQ,
    input  logic [XLEN-1:0]   I_ADDR,
    input  logic              I_ABORT,
    output logic              I_DONE,
    output logic [ILEN-1:0]   I_RDATA,
    output logic              I_ERR,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [XLEN-1:0]   D_ADDR,
    input  logic [XLEN-1:0]   D_WDATA,
    input  logic [STRB_W-1:0] D_WSTRB,
    output logic              D_DONE,
    output logic [XLEN-1:0]   D_RDATA,
    output logic              D_ERR,
    output logic              BUS_REQ,
    output logic              BUS_WE,
    output logic [XLEN-1:0]   BUS_ADDR,
    output logic [XLEN-1:0]   BUS_WDATA,
    output logic [STRB_W-1:0] BUS_WSTRB,
    input  logic              BUS_READY,
    input  logic              BUS_RVALID,
    input  logic [XLEN-1:0]   BUS_RDATA,
    input  logic              BUS_ERR
);

    localparam int c_burst_w = $clog2(D_BURST_MAX + 1);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(D_BURST_MAX);

    arb_state_t           r_state;
    owner_t               r_owner;
    logic                 r_abort;
    logic                 r_isel;
    logic [c_burst_w-1:0] r_burst_cnt;

    logic                 r_bus_req;
    logic                 r_bus_we;
    logic [XLEN-1:0]      r_bus_addr;
    logic [XLEN-1:0]      r_bus_wdata;
    logic [STRB_W-1:0]    r_bus_wstrb;

    logic                 r_i_done;
    logic                 r_i_err;
    logic [ILEN-1:0]      r_i_rdata;
    logic                 r_d_done;
    logic                 r_d_err;
    logic [XLEN-1:0]      r_d_rdata;

    logic                 w_d_win;
    logic                 w_i_win;
    logic                 w_grant;
    logic                 w_busy;
    logic                 w_expired;
    logic                 w_rsp;
    logic                 w_finish;
    logic                 w_fin_err;
    logic [XLEN-1:0]      w_fin_data;
    logic                 w_abort_now;

    assign w_d_win  = D_REQ && !(I_REQ && (r_burst_cnt == c_burst_max));
    assign w_i_win  = !w_d_win && I_REQ && !I_ABORT;
    assign w_grant  = (r_state == ST_IDLE) && (w_d_win || w_i_win);
    assign w_busy   = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

    // RVALID only counts after READY moved us to WAIT; a real response beats
    // a coincident timeout.
    assign w_rsp       = (r_state == ST_WAIT) && BUS_RVALID;
    assign w_finish    = w_rsp || (w_busy && w_expired);
    assign w_fin_err   = w_rsp ? BUS_ERR : 1'b1;
    assign w_fin_data  = w_rsp ? BUS_RDATA : '0;
    assign w_abort_now = r_abort || (I_ABORT && (r_owner == OWN_I));

    mem_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (CLK),
        .rst_n     (RESET),
        .i_clear   (w_grant),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_I;
            r_abort     <= 1'b0;
            r_isel      <= 1'b0;
            r_burst_cnt <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_i_done    <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_i_done  <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_done  <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_d_win && I_REQ) begin
                        if (r_burst_cnt != c_burst_max) begin
                            r_burst_cnt <= r_burst_cnt + c_burst_w'(1);
                        end
                    end else if (w_i_win || !I_REQ) begin
                        r_burst_cnt <= '0;
                    end

                    if (w_d_win) begin
                        r_owner     <= OWN_D;
                        r_bus_addr  <= align8(D_ADDR);
                        r_bus_we    <= D_WE;
                        r_bus_wdata <= D_WDATA;
                        r_bus_wstrb <= D_WSTRB;
                        r_bus_req   <= 1'b1;
                        r_abort     <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end else if (w_i_win) begin
                        r_owner     <= OWN_I;
                        r_bus_addr  <= align8(I_ADDR);
                        r_isel      <= I_ADDR[2];
                        r_bus_we    <= 1'b0;
                        r_bus_wdata <= '0;
                        r_bus_wstrb <= '1;
                        r_bus_req   <= 1'b1;
                        r_abort     <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (I_ABORT && (r_owner == OWN_I)) begin
                        r_abort <= 1'b1;
                    end
                    if (w_expired) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_RESP;
                    end else if (BUS_READY) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (I_ABORT && (r_owner == OWN_I)) begin
                        r_abort <= 1'b1;
                    end
                    if (w_finish) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_abort <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_finish) begin
                if (r_owner == OWN_D) begin
                    r_d_done  <= 1'b1;
                    r_d_err   <= w_fin_err;
                    r_d_rdata <= w_fin_data;
                end else if (!w_abort_now) begin
                    r_i_done  <= 1'b1;
                    r_i_err   <= w_fin_err;
                    r_i_rdata <= r_isel ? w_fin_data[XLEN-1:ILEN] : w_fin_data[ILEN-1:0];
                end
            end
        end
    end

    assign BUS_REQ   = r_bus_req;
    assign BUS_WE    = r_bus_we;
    assign BUS_ADDR  = r_bus_addr;
    assign BUS_WDATA = r_bus_wdata;
    assign BUS_WSTRB = r_bus_wstrb;
    assign I_DONE    = r_i_done;
    assign I_ERR     = r_i_err;
    assign I_RDATA   = r_i_rdata;
    assign D_DONE    = r_d_done;
    assign D_ERR     = r_d_err;
    assign D_RDATA   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// ==========================================================================
module tb_mem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        I_REQ;
    logic [63:0] I_ADDR;
    logic        I_ABORT;
    logic        I_DONE;
    logic [31:0] I_RDATA;
    logic        I_ERR;
    logic        D_REQ;
    logic        D_WE;
    logic [63:0] D_ADDR;
    logic [63:0] D_WDATA;
    logic [7:0]  D_WSTRB;
    logic        D_DONE;
    logic [63:0] D_RDATA;
    logic        D_ERR;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [63:0] BUS_ADDR;
    logic [63:0] BUS_WDATA;
    logic [7:0]  BUS_WSTRB;
    logic        BUS_READY;
    logic        BUS_RVALID;
    logic [63:0] BUS_RDATA;
    logic        BUS_ERR;

    int checks;
    int errors;

    bit exp_is_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mem_arbiter #(
        .D_BURST_MAX    (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .I_REQ      (I_REQ),
        .I_ADDR     (I_ADDR),
        .I_ABORT    (I_ABORT),
        .I_DONE     (I_DONE),
        .I_RDATA    (I_RDATA),
        .I_ERR      (I_ERR),
        .D_REQ      (D_REQ),
        .D_WE       (D_WE),
        .D_ADDR     (D_ADDR),
        .D_WDATA    (D_WDATA),
        .D_WSTRB    (D_WSTRB),
        .D_DONE     (D_DONE),
        .D_RDATA    (D_RDATA),
        .D_ERR      (D_ERR),
        .BUS_REQ    (BUS_REQ),
        .BUS_WE     (BUS_WE),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_WDATA  (BUS_WDATA),
        .BUS_WSTRB  (BUS_WSTRB),
        .BUS_READY  (BUS_READY),
        .BUS_RVALID (BUS_RVALID),
        .BUS_RDATA  (BUS_RDATA),
        .BUS_ERR    (BUS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        RESET      = 1'b0;
        I_REQ      = 1'b0;
        I_ADDR     = '0;
        I_ABORT    = 1'b0;
        D_REQ      = 1'b0;
        D_WE       = 1'b0;
        D_ADDR     = '0;
        D_WDATA    = '0;
        D_WSTRB    = '0;
        BUS_READY  = 1'b0;
        BUS_RVALID = 1'b0;
        BUS_RDATA  = '0;
        BUS_ERR    = 1'b0;

        repeat (2) tick();
        check("rst_bus_req", BUS_REQ, 0);
        check("rst_i_done", I_DONE, 0);
        check("rst_d_done", D_DONE, 0);
        check("rst_bus_addr", BUS_ADDR, 0);
        check("rst_bus_wstrb", BUS_WSTRB, 0);
        RESET = 1'b1;
        tick();

        // Single fetch at minimum latency
        I_REQ = 1'b1; I_ADDR = 64'h1004;
        tick();
        check("f_bus_req", BUS_REQ, 1);
        check("f_bus_addr", BUS_ADDR, 64'h1000);
        check("f_bus_wstrb", BUS_WSTRB, 8'hFF);
        check("f_bus_we", BUS_WE, 0);
        BUS_READY = 1'b1;
        tick();
        BUS_READY = 1'b0;
        check("f_req_drop", BUS_REQ, 0);
        BUS_RVALID = 1'b1; BUS_RDATA = 64'hAAAA_BBBB_1111_2222;
        tick();
        BUS_RVALID = 1'b0;
        check("f_i_done", I_DONE, 1);
        check("f_i_rdata", I_RDATA, 32'hAAAA_BBBB);
        check("f_i_err", I_ERR, 0);
        check("f_d_done", D_DONE, 0);
        I_REQ = 1'b0;
        tick();
        check("f_done_pulse", I_DONE, 0);

        // Store with three READY stalls
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 64'h2000; D_WSTRB = 8'h0F; D_WDATA = 64'h55;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("st_req", BUS_REQ, 1);
            check("st_we", BUS_WE, 1);
            check("st_wstrb", BUS_WSTRB, 8'h0F);
            tick();
        end
        check("st_wdata", BUS_WDATA, 64'h55);
        check("st_addr", BUS_ADDR, 64'h2000);
        BUS_READY = 1'b1;
        tick();
        BUS_READY = 1'b0;
        BUS_RVALID = 1'b1; BUS_RDATA = '0;
        tick();
        BUS_RVALID = 1'b0;
        check("st_d_done", D_DONE, 1);
        check("st_d_err", D_ERR, 0);
        D_REQ = 1'b0;
        tick();
        check("st_done_pulse", D_DONE, 0);

        // Both requesters held: burst limit forces fetch every fifth grant
        I_REQ = 1'b1; I_ADDR = 64'h3000;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 64'h400C; D_WSTRB = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("arb_addr", BUS_ADDR, exp_is_d[k] ? 64'h4008 : 64'h3000);
            BUS_READY = 1'b1;
            tick();
            BUS_READY = 1'b0;
            BUS_RVALID = 1'b1; BUS_RDATA = 64'h0123_4567_89AB_CDEF;
            tick();
            BUS_RVALID = 1'b0;
            check("arb_d_done", D_DONE, exp_is_d[k]);
            check("arb_i_done", I_DONE, !exp_is_d[k]);
            if (!exp_is_d[k]) check("arb_i_rdata", I_RDATA, 32'h89AB_CDEF);
            if (k == 9) begin
                I_REQ = 1'b0; D_REQ = 1'b0;
            end
            tick();
        end

        // Abort during WAIT, then a fresh fetch
        I_REQ = 1'b1; I_ADDR = 64'h5000;
        tick();
        BUS_READY = 1'b1;
        tick();
        BUS_READY = 1'b0;
        I_ABORT = 1'b1;
        tick();
        I_ABORT = 1'b0; I_ADDR = 64'h6004;
        BUS_RVALID = 1'b1; BUS_RDATA = 64'hFFFF_0000_FFFF_0000;
        tick();
        BUS_RVALID = 1'b0;
        check("ab_no_done", I_DONE, 0);
        tick();
        check("ab_idle_gap", BUS_REQ, 0);
        tick();
        check("ab_new_req", BUS_REQ, 1);
        check("ab_new_addr", BUS_ADDR, 64'h6000);
        BUS_READY = 1'b1;
        tick();
        BUS_READY = 1'b0;
        BUS_RVALID = 1'b1; BUS_RDATA = 64'h1234_5678_9ABC_DEF0;
        tick();
        BUS_RVALID = 1'b0;
        check("ab_done", I_DONE, 1);
        check("ab_rdata", I_RDATA, 32'h1234_5678);
        I_REQ = 1'b0;
        tick();

        // Timeout: READY/RVALID never come
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 64'h7000; BUS_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        for (int c = 1; c < 8; c++) begin
            check("to_no_done", D_DONE, 0);
            check("to_req_held", BUS_REQ, 1);
            tick();
        end
        check("to_done", D_DONE, 1);
        check("to_err", D_ERR, 1);
        check("to_rdata", D_RDATA, 0);
        check("to_req_drop", BUS_REQ, 0);
        D_REQ = 1'b0;
        tick();
        BUS_RVALID = 1'b1;
        tick();
        BUS_RVALID = 1'b0;
        check("late_d_done", D_DONE, 0);
        check("late_i_done", I_DONE, 0);
        check("late_bus_req", BUS_REQ, 0);

        // Asynchronous reset in WAIT, then regrant of the held request
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 64'h8000; D_WSTRB = 8'hFF; D_WDATA = 64'h77;
        tick();
        check("rs_req_pre", BUS_REQ, 1);
        BUS_READY = 1'b1;
        tick();
        BUS_READY = 1'b0;
        check("rs_addr_pre", BUS_ADDR, 64'h8000);
        #2 RESET = 1'b0;
        #1;
        check("rs_bus_req", BUS_REQ, 0);
        check("rs_bus_addr", BUS_ADDR, 0);
        check("rs_bus_we", BUS_WE, 0);
        check("rs_d_done", D_DONE, 0);
        BUS_RVALID = 1'b1;
        tick();
        BUS_RVALID = 1'b0;
        check("rs_no_done", D_DONE, 0);
        RESET = 1'b1;
        tick();
        check("rs_regrant_req", BUS_REQ, 1);
        check("rs_regrant_addr", BUS_ADDR, 64'h8000);
        check("rs_regrant_we", BUS_WE, 1);
        BUS_READY = 1'b1;
        tick();
        BUS_READY = 1'b0;
        BUS_RVALID = 1'b1; BUS_RDATA = '0;
        tick();
        BUS_RVALID = 1'b0;
        check("rs_d_done", D_DONE, 1);
        D_REQ = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
